// File: rtl/alu_share_arbiter.sv
// ============================================================================
//  Module      : alu_share_arbiter
//  Description : Round-robin arbiter sharing one external combinational ALU
//                (add/sub/and/xor with overflow) between two requesters.
//                One operation in flight; IDLE -> EXEC -> RESP -> IDLE.
//                Optional macro CC_UPDATE_EN: registered {ZF,SF,OF} condition
//                codes, updated only by requester-0 operations.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_share_arbiter #(
   parameter int WIDTH = 64
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [1:0]       req_valid_i,
   output logic [1:0]       req_ready_o,
   input  logic [1:0]       req_op0_i,
   input  logic [WIDTH-1:0] req_a0_i,
   input  logic [WIDTH-1:0] req_b0_i,
   input  logic [1:0]       req_op1_i,
   input  logic [WIDTH-1:0] req_a1_i,
   input  logic [WIDTH-1:0] req_b1_i,
   output logic [1:0]       rsp_valid_o,
   input  logic [1:0]       rsp_ready_i,
   output logic [WIDTH-1:0] rsp_data_o,
   output logic             rsp_ovf_o,
   output logic [1:0]       alu_ctrl_o,
   output logic [WIDTH-1:0] alu_a_o,
   output logic [WIDTH-1:0] alu_b_o,
   input  logic [WIDTH-1:0] alu_out_i,
   input  logic             alu_ovf_i,
   output logic [2:0]       cc_out_o,
   output logic             busy_o
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EXEC = 2'd1,
      ST_RESP = 2'd2
   } state_t;

   state_t           state_q;
   logic             rr_ptr_q;
   logic             owner_q;
   logic             busy_q;
   logic [1:0]       rsp_valid_q;
   logic [WIDTH-1:0] rsp_data_q;
   logic             rsp_ovf_q;
   logic [1:0]       alu_ctrl_q;
   logic [WIDTH-1:0] alu_a_q;
   logic [WIDTH-1:0] alu_b_q;

   logic             w_gnt_vld;
   logic             w_gnt_idx;
   logic [1:0]       w_op;
   logic [WIDTH-1:0] w_a;
   logic [WIDTH-1:0] w_b;

   // Grant selection: a lone requester wins outright, a tie goes to rr_ptr.
   always_comb begin
      w_gnt_vld = 1'b0;
      w_gnt_idx = rr_ptr_q;
      if (state_q == ST_IDLE) begin
         case (req_valid_i)
            2'b01: begin
               w_gnt_vld = 1'b1;
               w_gnt_idx = 1'b0;
            end
            2'b10: begin
               w_gnt_vld = 1'b1;
               w_gnt_idx = 1'b1;
            end
            2'b11: begin
               w_gnt_vld = 1'b1;
               w_gnt_idx = rr_ptr_q;
            end
            default: begin
               w_gnt_vld = 1'b0;
               w_gnt_idx = rr_ptr_q;
            end
         endcase
      end
   end

   // Operand mux for the granted requester.
   assign w_op = w_gnt_idx ? req_op1_i : req_op0_i;
   assign w_a  = w_gnt_idx ? req_a1_i  : req_a0_i;
   assign w_b  = w_gnt_idx ? req_b1_i  : req_b0_i;

   // Accept is masked while reset is held so every output reads zero in reset.
   assign req_ready_o = (w_gnt_vld && rst_n) ? (w_gnt_idx ? 2'b10 : 2'b01) : 2'b00;

   // Main sequencer: grant, execute, hold response until the owner accepts.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         rr_ptr_q    <= 1'b0;
         owner_q     <= 1'b0;
         busy_q      <= 1'b0;
         rsp_valid_q <= 2'b00;
         rsp_data_q  <= '0;
         rsp_ovf_q   <= 1'b0;
         alu_ctrl_q  <= 2'b00;
         alu_a_q     <= '0;
         alu_b_q     <= '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (w_gnt_vld) begin
                  alu_ctrl_q <= w_op;
                  alu_a_q    <= w_a;
                  alu_b_q    <= w_b;
                  owner_q    <= w_gnt_idx;
                  busy_q     <= 1'b1;
                  state_q    <= ST_EXEC;
               end
            end
            ST_EXEC: begin
               rsp_data_q  <= alu_out_i;
               rsp_ovf_q   <= alu_ovf_i;
               rsp_valid_q <= owner_q ? 2'b10 : 2'b01;
               state_q     <= ST_RESP;
            end
            ST_RESP: begin
               if (rsp_ready_i[owner_q]) begin
                  rsp_valid_q <= 2'b00;
                  busy_q      <= 1'b0;
                  rr_ptr_q    <= ~owner_q;
                  state_q     <= ST_IDLE;
               end
            end
            default: begin
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   assign rsp_valid_o = rsp_valid_q;
   assign rsp_data_o  = rsp_data_q;
   assign rsp_ovf_o   = rsp_ovf_q;
   assign alu_ctrl_o  = alu_ctrl_q;
   assign alu_a_o     = alu_a_q;
   assign alu_b_o     = alu_b_q;
   assign busy_o      = busy_q;

`ifdef CC_UPDATE_EN
   logic [2:0] cc_q;

   // Condition codes latch with the result, but only for requester-0 ops.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cc_q <= 3'b000;
      end else if ((state_q == ST_EXEC) && !owner_q) begin
         cc_q <= {(alu_out_i == '0), alu_out_i[WIDTH-1], alu_ovf_i};
      end
   end

   assign cc_out_o = cc_q;
`else
   assign cc_out_o = 3'b000;
`endif

endmodule

`default_nettype wire
